// File: rtl/pico_pkg.sv
// Shared types and helpers for the SPI frame decoder: FSM state encoding,
// command-word field positions and the address-advance rule.
package pico_pkg;

    typedef enum logic [1:0] {
        CMD   = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        ERR   = 2'd3
    } frame_state_t;

    localparam int DEFAULT_DATA_W = 8;
    localparam int RNW_BIT        = DEFAULT_DATA_W - 1;

    // Next burst address; wrap to 0 past the last implemented register is silent.
    function automatic int advance_addr(input int addr, input int num_regs, input bit auto_inc);
        if (!auto_inc) begin
            return addr;
        end
        return (addr == num_regs - 1) ? 0 : addr + 1;
    endfunction

endpackage

// File: rtl/spi_word_deserializer.sv
// MSB-first MOSI deserializer: presents the completed word combinationally on
// the edge where the last bit arrives, so the caller can register it there.
module spi_word_deserializer #(
    parameter int DATA_W = 8
) (
    input  logic              sclk,
    input  logic              frame_rstn,
    input  logic              mosi,
    output logic              word_valid,
    output logic [DATA_W-1:0] word
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-2:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign word       = {shift_q, mosi};
    assign word_valid = (cnt_q == CNT_W'(DATA_W - 1));

    always_comb begin
        shift_d = word[DATA_W-2:0];
        cnt_d   = word_valid ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge sclk or negedge frame_rstn) begin
        if (!frame_rstn) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_frame_decoder.sv
// SPI frame decoder: command word then a burst of data words per cs_n frame,
// producing register-file write strobes or POCI read-prefetch strobes.
module spi_frame_decoder
    import pico_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 7,
    parameter int NUM_REGS = 64,
    parameter int AUTO_INC = 1
) (
    input  logic              sclk,
    input  logic              rstn,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              word_done,
    output logic              frame_err,
    output logic              busy
);

    localparam int RNW = DATA_W - 1;

    logic              frame_rstn;
    logic              word_valid;
    logic [DATA_W-1:0] word;
    logic [ADDR_W-1:0] start_addr;
    logic              rnw;

    // A high cs_n clears the frame exactly like reset, without synchronisation.
    assign frame_rstn = rstn & ~cs_n;
    assign start_addr = word[ADDR_W-1:0];
    assign rnw        = word[RNW];

    spi_word_deserializer #(
        .DATA_W (DATA_W)
    ) u_deser (
        .sclk       (sclk),
        .frame_rstn (frame_rstn),
        .mosi       (mosi),
        .word_valid (word_valid),
        .word       (word)
    );

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return ADDR_W'(advance_addr(int'(a), NUM_REGS, AUTO_INC != 0));
    endfunction

    frame_state_t      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic              word_done_q, word_done_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        word_done_d = word_valid;
        frame_err_d = frame_err_q;
        busy_d      = 1'b1;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_addr_d   = rd_addr_q;

        if (word_valid) begin
            case (state_q)
                CMD: begin
                    if (int'(start_addr) >= NUM_REGS) begin
                        state_d     = ERR;
                        frame_err_d = 1'b1;
                    end else if (rnw) begin
                        state_d   = READ;
                        rd_en_d   = 1'b1;
                        rd_addr_d = start_addr;
                        addr_d    = next_addr(start_addr);
                    end else begin
                        state_d = WRITE;
                        addr_d  = start_addr;
                    end
                end
                WRITE: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = word;
                    addr_d    = next_addr(addr_q);
                end
                // The word arriving during a read is a dummy; only prefetch the next register.
                READ: begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = addr_q;
                    addr_d    = next_addr(addr_q);
                end
                ERR: begin
                    frame_err_d = 1'b1;
                end
                default: begin
                    state_d = CMD;
                end
            endcase
        end
    end

    always_ff @(posedge sclk or negedge frame_rstn) begin
        if (!frame_rstn) begin
            state_q     <= CMD;
            addr_q      <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            word_done_q <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            word_done_q <= word_done_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    // Address/data buses survive the end of a frame so a slow consumer still sees them.
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_addr_q <= '0;
        end else begin
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign word_done = word_done_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Scoreboard bench for spi_frame_decoder: directed frames push expected strobes,
// a monitor pops and compares them whenever the DUT strobes.
module tb_spi_frame_decoder;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 7;
    localparam int NUM_REGS = 64;
    localparam int AUTO_INC = 1;

    logic              sclk;
    logic              rstn;
    logic              cs_n;
    logic              mosi;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              word_done;
    logic              frame_err;
    logic              busy;

    spi_frame_decoder #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .AUTO_INC (AUTO_INC)
    ) dut (
        .sclk      (sclk),
        .rstn      (rstn),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .word_done (word_done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    int checks = 0;
    int errors = 0;
    int wd_count = 0;
    logic [ADDR_W+DATA_W-1:0] exp_wr[$];
    logic [ADDR_W-1:0]        exp_rd[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge sclk) begin
        #1;
        if (word_done === 1'b1) wd_count++;
        if (wr_en === 1'b1) begin
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: got addr=0x%0h data=0x%0h, expected no write", wr_addr, wr_data);
            end else begin
                logic [ADDR_W+DATA_W-1:0] e;
                e = exp_wr.pop_front();
                check("wr_txn", {wr_addr, wr_data}, e);
                $display("t=%0t write addr=0x%0h data=0x%0h", $time, wr_addr, wr_data);
            end
        end
        if (rd_en === 1'b1) begin
            if (exp_rd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got addr=0x%0h, expected no read", rd_addr);
            end else begin
                logic [ADDR_W-1:0] e;
                e = exp_rd.pop_front();
                check("rd_txn", rd_addr, e);
                $display("t=%0t read  addr=0x%0h", $time, rd_addr);
            end
        end
    end

    task automatic send_bits(input logic [DATA_W-1:0] w, input int n);
        for (int i = DATA_W - 1; i >= DATA_W - n; i--) begin
            @(negedge sclk);
            cs_n = 1'b0;
            mosi = w[i];
        end
    endtask

    task automatic send_word(input logic [DATA_W-1:0] w);
        send_bits(w, DATA_W);
    endtask

    // Let the word just shifted complete, then sample after the edge.
    task automatic after_edge();
        @(posedge sclk);
        #2;
    endtask

    task automatic end_frame();
        @(negedge sclk);
        cs_n = 1'b1;
        mosi = 1'b0;
        #1;
    endtask

    task automatic idle();
        repeat (2) @(negedge sclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b1;
        cs_n = 1'b1;
        mosi = 1'b0;
        #1 rstn = 1'b0;
        repeat (2) @(negedge sclk);
        #1;
        check("reset_outputs", {wr_en, wr_addr, wr_data, rd_en, rd_addr, word_done, frame_err, busy}, 0);
        @(negedge sclk);
        rstn = 1'b1;
        idle();

        // Write burst
        wd_count = 0;
        exp_wr.push_back({7'h05, 8'hA1});
        exp_wr.push_back({7'h06, 8'hB2});
        send_word(8'h05);
        after_edge();
        check("busy_in_frame", busy, 1);
        send_word(8'hA1);
        send_word(8'hB2);
        after_edge();
        check("write_frame_err", frame_err, 0);
        end_frame();
        check("write_busy_after_cs", busy, 0);
        check("write_wr_en_after_cs", wr_en, 0);
        check("write_addr_held", wr_addr, 7'h06);
        check("write_data_held", wr_data, 8'hB2);
        check("write_word_done_count", wd_count, 3);
        idle();

        // Read burst
        wd_count = 0;
        exp_rd.push_back(7'h0A);
        exp_rd.push_back(7'h0B);
        exp_rd.push_back(7'h0C);
        send_word(8'h8A);
        send_word(8'h00);
        send_word(8'h00);
        end_frame();
        check("read_word_done_count", wd_count, 3);
        idle();

        // Wrap at last implemented register
        exp_wr.push_back({7'h3F, 8'h11});
        exp_wr.push_back({7'h00, 8'h22});
        send_word(8'h3F);
        send_word(8'h11);
        send_word(8'h22);
        end_frame();
        idle();

        // Out-of-range start address
        send_word(8'h50);
        after_edge();
        check("oor_err_after_cmd", frame_err, 1);
        send_word(8'hFF);
        after_edge();
        check("oor_err_sticky", frame_err, 1);
        end_frame();
        check("oor_err_cleared", frame_err, 0);
        idle();
        exp_wr.push_back({7'h01, 8'h33});
        send_word(8'h01);
        send_word(8'h33);
        end_frame();
        idle();

        // Abort mid-word
        send_word(8'h02);
        send_bits(8'hF8, 5);
        after_edge();
        check("abort_busy_before", busy, 1);
        end_frame();
        check("abort_busy_after", busy, 0);
        check("abort_frame_err", frame_err, 0);
        idle();
        exp_wr.push_back({7'h03, 8'h44});
        send_word(8'h03);
        send_word(8'h44);
        end_frame();
        idle();

        // Reset mid-burst
        exp_wr.push_back({7'h07, 8'h55});
        send_word(8'h07);
        send_word(8'h55);
        after_edge();
        rstn = 1'b0;
        #1;
        check("midburst_reset_outputs", {wr_en, wr_addr, wr_data, rd_en, rd_addr, word_done, frame_err, busy}, 0);
        @(negedge sclk);
        cs_n = 1'b1;
        rstn = 1'b1;
        idle();
        exp_wr.push_back({7'h10, 8'h66});
        send_word(8'h10);
        send_word(8'h66);
        end_frame();
        idle();

        repeat (3) @(negedge sclk);
        check("wr_queue_drained", exp_wr.size(), 0);
        check("rd_queue_drained", exp_rd.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
